// File: rtl/s2_cfg_loader.sv
// Bit-serial configuration loader for the s2 cell array: assembles a shadow
// frame LSB-first, checks trailing even parity, and commits atomically to cfg_bus.
module s2_cfg_loader #(
  parameter int NCELLS = 4,
  parameter int CFG_W  = 8
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      cfg_in,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [NCELLS*CFG_W-1:0]   cfg_bus,
  output logic                      cell_en,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int TOTAL = NCELLS * CFG_W;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int IDX_W = $clog2(TOTAL);

  typedef enum logic [2:0] {IDLE, LOAD, PAR, DONE, ERR} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [TOTAL-1:0]   shadow_reg;
  logic [TOTAL-1:0]   bus_reg;
  logic               configured_reg;
  logic               cell_en_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               err_reg;

  logic               xfer;

  assign cfg_ready = (state_reg == LOAD) || (state_reg == PAR);
  assign xfer      = cfg_ready && cfg_valid;
  assign cfg_bus   = bus_reg;
  assign cell_en   = cell_en_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      shadow_reg     <= '0;
      bus_reg        <= '0;
      configured_reg <= 1'b0;
      cell_en_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_reg   <= LOAD;
            cnt_reg     <= '0;
            shadow_reg  <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            busy_reg    <= 1'b1;
            cell_en_reg <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            // Abort beats a simultaneous transfer; the partial frame is dropped.
            state_reg   <= IDLE;
            shadow_reg  <= '0;
            busy_reg    <= 1'b0;
            cell_en_reg <= configured_reg;
          end else if (xfer) begin
            shadow_reg[cnt_reg[IDX_W-1:0]] <= cfg_in;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(TOTAL - 1)) begin
              state_reg <= PAR;
            end
          end
        end
        PAR: begin
          if (abort) begin
            state_reg   <= IDLE;
            shadow_reg  <= '0;
            busy_reg    <= 1'b0;
            cell_en_reg <= configured_reg;
          end else if (xfer) begin
            busy_reg <= 1'b0;
            if (((^shadow_reg) ^ cfg_in) == 1'b0) begin
              state_reg      <= DONE;
              bus_reg        <= shadow_reg;
              configured_reg <= 1'b1;
              cell_en_reg    <= 1'b1;
              done_reg       <= 1'b1;
            end else begin
              state_reg   <= ERR;
              err_reg     <= 1'b1;
              cell_en_reg <= configured_reg;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s2_cfg_loader.sv
// Directed bench for s2_cfg_loader with NCELLS=2 (16-bit frames); all checks
// go through one task and are sampled 1ns after the rising edge.
module tb_s2_cfg_loader;

  localparam int NCELLS = 2;
  localparam int CFG_W  = 8;
  localparam int TOTAL  = NCELLS * CFG_W;

  logic             clk = 1'b0;
  logic             clr;
  logic             start;
  logic             abort;
  logic             cfg_in;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [TOTAL-1:0] cfg_bus;
  logic             cell_en;
  logic             busy;
  logic             done;
  logic             err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  s2_cfg_loader #(.NCELLS(NCELLS), .CFG_W(CFG_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .abort     (abort),
    .cfg_in    (cfg_in),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_bus   (cfg_bus),
    .cell_en   (cell_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends data[lo..hi] LSB-first, one accepted bit per cycle.
  task automatic send_bits(input logic [15:0] data, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cfg_valid = 1'b1;
      cfg_in    = data[i];
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic send_parity(input logic p);
    cfg_valid = 1'b1;
    cfg_in    = p;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] bus, input logic en,
                               input logic bsy, input logic dn, input logic er, input logic rdy);
    check({tag, ".cfg_bus"},   cfg_bus,   bus);
    check({tag, ".cell_en"},   cell_en,   en);
    check({tag, ".busy"},      busy,      bsy);
    check({tag, ".done"},      done,      dn);
    check({tag, ".err"},       err,       er);
    check({tag, ".cfg_ready"}, cfg_ready, rdy);
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; abort = 1'b0; cfg_in = 1'b0; cfg_valid = 1'b0;

    // 1. reset with random inputs, reset must win
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); abort = 1'($urandom);
      cfg_in = 1'($urandom); cfg_valid = 1'($urandom);
      tick();
    end
    check_outputs("reset", 16'h0000, 0, 0, 0, 0, 0);
    clr = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
    tick();

    // 2. good frame 0xFFF6, 14 ones -> parity 0
    start_frame();
    check("start.busy", busy, 1'b1);
    check("start.cfg_ready", cfg_ready, 1'b1);
    send_bits(16'hFFF6, 0, 15);
    check("preparity.cfg_bus", cfg_bus, 16'h0000);
    check("preparity.busy", busy, 1'b1);
    send_parity(1'b0);
    check_outputs("good", 16'hFFF6, 1, 0, 1, 0, 0);

    // 3. same frame, wrong parity: bus held, cell_en sticky
    start_frame();
    check("restart.cell_en", cell_en, 1'b0);
    check("restart.done", done, 1'b0);
    send_bits(16'hFFF6, 0, 15);
    send_parity(1'b1);
    check_outputs("badpar", 16'hFFF6, 1, 0, 0, 1, 0);

    // 4. 0x5AC3 (8 ones, parity 0) with a 5-cycle stall carrying garbage
    start_frame();
    send_bits(16'h5AC3, 0, 4);
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b0;
      cfg_in    = ~cfg_in;
      tick();
    end
    check("stall.busy", busy, 1'b1);
    check("stall.cfg_bus", cfg_bus, 16'hFFF6);
    send_bits(16'h5AC3, 5, 15);
    send_parity(1'b0);
    check_outputs("stall", 16'h5AC3, 1, 0, 1, 0, 0);

    // 5. abort after 7 bits together with a valid bit
    start_frame();
    send_bits(16'hFFFF, 0, 6);
    abort = 1'b1; cfg_valid = 1'b1; cfg_in = 1'b1;
    tick();
    abort = 1'b0; cfg_valid = 1'b0;
    check_outputs("abort", 16'h5AC3, 1, 0, 0, 0, 0);
    // 0x1234 has 5 ones -> parity 1
    start_frame();
    send_bits(16'h1234, 0, 15);
    send_parity(1'b1);
    check_outputs("postabort", 16'h1234, 1, 0, 1, 0, 0);

    // 6a. start during LOAD is ignored; 0xA5F0 has 8 ones -> parity 0
    start_frame();
    send_bits(16'hA5F0, 0, 3);
    start_frame();
    check("ignstart.busy", busy, 1'b1);
    send_bits(16'hA5F0, 4, 15);
    send_parity(1'b0);
    check_outputs("ignstart", 16'hA5F0, 1, 0, 1, 0, 0);

    // 6b. reset mid-frame clears everything, including cell_en
    start_frame();
    send_bits(16'h00FF, 0, 4);
    clr = 1'b0;
    tick();
    check_outputs("midreset", 16'h0000, 0, 0, 0, 0, 0);
    clr = 1'b1;
    tick();
    check_outputs("afterreset", 16'h0000, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s2_cfg_loader.md
Name: s2_cfg_loader

Overview:
Serial configuration loader sitting directly upstream of the s2 logic-cell array. Receives a bit-serial configuration stream over a valid/ready handshake, assembles per-cell words (d[3:0], A0, B0, A1, B1) in a shadow register, and checks a trailing even-parity bit. On a clean frame it commits the shadow to the parallel bus that drives the cells. It gates the cells off while a load is in progress.

Parameters:
NCELLS, 4, number of s2 cells driven
CFG_W, 8, configuration bits per cell (fixed layout, do not override)

Ports:
clk  in  1  clock, all state updates on rising edge
clr  in  1  synchronous reset, active-low
start  in  1  begin a configuration frame (pulse)
abort  in  1  cancel the frame in progress
cfg_in  in  1  serial configuration bit
cfg_valid  in  1  cfg_in is valid this cycle
cfg_ready  out  1  loader accepts a bit this cycle
cfg_bus  out  NCELLS*CFG_W  committed configuration; cell i at [8i+7:8i]: [3:0]=d, [4]=A0, [5]=B0, [6]=A1, [7]=B1
cell_en  out  1  cells may run; low drives their clr
busy  out  1  frame in progress
done  out  1  last frame committed successfully
err  out  1  last frame failed parity

Behaviour:
- Reset (clr=0 at a rising edge) forces state IDLE, bit counter 0, and shadow 0. Outputs cfg_bus=0, cell_en=0, busy=0, done=0, err=0, cfg_ready=0. Reset wins over every other input.
- States: IDLE, LOAD, PAR, DONE, ERR. All outputs are registered or decoded from state only.
- IDLE/DONE/ERR plus start=1 -> LOAD. On that edge: counter cleared, done and err cleared, busy set, cell_en cleared.
- start is ignored while in LOAD or PAR.
- Transfer rule: a bit is accepted on an edge where cfg_valid and cfg_ready are both 1. cfg_ready=1 exactly in LOAD and PAR.
- LOAD: the k-th accepted bit (k from 0) is written to shadow[k]. The counter increments per accepted bit. Accepting bit k=NCELLS*CFG_W-1 moves to PAR.
- cfg_valid=0 stalls the loader indefinitely with no timeout. Shadow and counter hold.
- PAR: the accepted bit p is checked against the shadow. Good frame means XOR(shadow) ^ p == 0 (even parity over data plus parity bit).
  - Good frame: on the same edge, cfg_bus is loaded from shadow, state -> DONE, done=1, cell_en=1, busy=0.
  - Bad frame: state -> ERR, err=1, busy=0. cfg_bus keeps its previous value. cell_en=1 only if a prior good commit exists (sticky "configured" flag, cleared by reset only).
- abort=1 in LOAD or PAR -> IDLE on the next edge. Shadow is discarded, cfg_bus is unchanged, busy=0, and cell_en is restored per the configured flag. abort in other states has no effect.
- abort and a valid transfer on the same edge: abort wins and the bit is dropped.
- cfg_bus never changes except on a good-parity commit or reset. No partial updates are visible.
- Counter width is clog2(NCELLS*CFG_W+1). There is no wrap-around, because the counter is cleared on start.
- Minimum frame latency is NCELLS*CFG_W+1 accepted bits. done is visible the cycle after the parity bit is accepted.

Test Plan:
1. Reset: hold clr=0 for 2 cycles with random inputs -> cfg_bus=0, cell_en=0, busy=0, done=0, err=0, cfg_ready=0.
2. Good frame, NCELLS=2: start, then stream bytes 0xF6 (cell0 d=0110, A0=B0=A1=B1=1) and 0xFF LSB-first, parity 0 -> cfg_bus=16'hFFF6, done=1, cell_en=1, busy=0 one cycle after the parity bit.
3. Bad parity: same frame with parity 1 -> err=1, done=0, cfg_bus remains 16'hFFF6 from test 2, cell_en=1.
4. Stall: deassert cfg_valid for 5 cycles mid-frame with garbage on cfg_in -> counter frozen, final cfg_bus is identical to the unstalled run.
5. Abort: after 7 bits assert abort together with cfg_valid=1 -> IDLE, busy=0, cfg_bus unchanged, the 7 bits are discarded. A subsequent full frame commits correctly.
6. Reset mid-frame: clr=0 during LOAD -> all outputs return to reset values, including cell_en=0 even after a prior good commit. start during LOAD is ignored.
